// File: rtl/pc_redirect.sv
`default_nettype none
// ============================================================================
//  Module      : pc_redirect
//  Description : Fetch-stage PC register with branch/jump delay-slot redirect,
//                exception/ERET override and a one-entry pending-redirect hold
//                used while the fetch stage is stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          EXC_PRIO = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        branch_valid,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        flush_exc,
    input  logic [31:0] exc_pc,
    output logic [31:0] pc_f,
    output logic        inst_req,
    output logic        ds_f,
    output logic        adel_f,
    output logic        pend_o
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Nonzero EXC_PRIO lets an exception beat a same-cycle branch/jump redirect.
    localparam bit EXC_FIRST = (EXC_PRIO != 0);

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;

    logic        w_accept;
    logic        w_redir;
    logic [31:0] w_redir_target;
    logic        w_exc_take;
    logic        w_redirect_any;
    logic [31:0] w_next_target;

    // Decode a branch/jump acceptance and pick the winning redirect target.
    always_comb begin
        w_accept       = (branch_valid | jump_valid) & ~stall_d;
        // A jump always redirects; a branch only when taken. Jump wins if both.
        w_redir        = w_accept & (jump_valid | branch_taken);
        w_redir_target = jump_valid ? jump_target : branch_target;
        w_exc_take     = flush_exc & (EXC_FIRST | ~w_redir);
        w_redirect_any = w_exc_take | w_redir;
        w_next_target  = w_exc_take ? exc_pc : w_redir_target;
    end

    // PC register, pending-redirect register and RUN/HOLD state machine.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc      <= RESET_PC;
            r_state   <= ST_RUN;
            r_pend_pc <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!stall_f) begin
                        // The current pc_f is the delay slot; target follows it.
                        r_pc <= w_redirect_any ? w_next_target : (r_pc + 32'd4);
                    end else if (w_redirect_any) begin
                        r_pend_pc <= w_next_target;
                        r_state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall_f) begin
                        r_pc    <= flush_exc ? exc_pc : r_pend_pc;
                        r_state <= ST_RUN;
                    end else if (flush_exc) begin
                        // Only an exception may replace a held redirect.
                        r_pend_pc <= exc_pc;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Output decode; everything is quiet while reset is held.
    always_comb begin
        pc_f     = r_pc;
        inst_req = resetn & ~flush_exc;
        ds_f     = resetn & w_accept;
        adel_f   = resetn & (r_pc[1:0] != 2'b00);
        pend_o   = (r_state == ST_HOLD);
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_redirect
//  Description : Directed self-checking bench for pc_redirect. Expected fetch
//                addresses are queued when a step is driven and popped after
//                the clock edge that should produce them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_redirect;

    logic        clk;
    logic        resetn;
    logic        stall_f;
    logic        stall_d;
    logic        branch_valid;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        flush_exc;
    logic [31:0] exc_pc;
    logic [31:0] pc_f;
    logic        inst_req;
    logic        ds_f;
    logic        adel_f;
    logic        pend_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    pc_redirect #(
        .RESET_PC (32'hBFC0_0000),
        .EXC_PRIO (1)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .branch_valid  (branch_valid),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .flush_exc     (flush_exc),
        .exc_pc        (exc_pc),
        .pc_f          (pc_f),
        .inst_req      (inst_req),
        .ds_f          (ds_f),
        .adel_f        (adel_f),
        .pend_o        (pend_o)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue the expected pc_f, take one clock edge, then pop and compare.
    task automatic step(input string tag, input logic [31:0] exp);
        logic [31:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, pc_f, e);
        end
    endtask

    task automatic idle_inputs();
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        branch_valid  = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump_valid    = 1'b0;
        jump_target   = 32'h0;
        flush_exc     = 1'b0;
        exc_pc        = 32'h0;
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc",       pc_f,     32'hBFC0_0000);
        chk("rst_inst_req", inst_req, 32'd0);
        chk("rst_ds",       ds_f,     32'd0);
        chk("rst_pend",     pend_o,   32'd0);
        chk("rst_adel",     adel_f,   32'd0);

        // Reset release and sequential fetch
        resetn = 1'b1;
        #1;
        chk("rel_pc",       pc_f,     32'hBFC0_0000);
        chk("rel_inst_req", inst_req, 32'd1);
        step("seq_4",  32'hBFC0_0004);
        step("seq_8",  32'hBFC0_0008);
        step("seq_c",  32'hBFC0_000C);
        step("seq_10", 32'hBFC0_0010);

        // Taken branch, no stall: one-clock redirect after the delay slot
        branch_valid = 1'b1; branch_taken = 1'b1; branch_target = 32'hBFC0_0100;
        #1;
        chk("br_ds", ds_f, 32'd1);
        step("br_taken", 32'hBFC0_0100);
        idle_inputs();

        // Not-taken branch still marks the delay slot
        branch_valid = 1'b1; branch_taken = 1'b0; branch_target = 32'hBFC0_0F00;
        #1;
        chk("nt_ds", ds_f, 32'd1);
        step("br_not_taken", 32'hBFC0_0104);
        idle_inputs();
        #1;
        chk("ds_idle", ds_f, 32'd0);

        // Branch under fetch stall: held pending, later branch ignored
        stall_f = 1'b1;
        branch_valid = 1'b1; branch_taken = 1'b1; branch_target = 32'hBFC0_0300;
        step("stall_hold1", 32'hBFC0_0104);
        chk("stall_pend1", pend_o, 32'd1);
        branch_valid = 1'b0;
        jump_valid = 1'b1; jump_target = 32'h1111_1110;
        step("stall_hold2", 32'hBFC0_0104);
        jump_valid = 1'b0;
        step("stall_hold3", 32'hBFC0_0104);
        chk("stall_pend3", pend_o, 32'd1);
        stall_f = 1'b0;
        step("stall_release", 32'hBFC0_0300);
        chk("stall_pend_clr", pend_o, 32'd0);

        // Exception in HOLD overwrites the pending jump
        stall_f = 1'b1;
        jump_valid = 1'b1; jump_target = 32'hBFC0_0500;
        step("hold_j", 32'hBFC0_0300);
        jump_valid = 1'b0;
        flush_exc = 1'b1; exc_pc = 32'hBFC0_0380;
        #1;
        chk("hold_exc_inst_req", inst_req, 32'd0);
        step("hold_exc", 32'hBFC0_0300);
        flush_exc = 1'b0; exc_pc = 32'h0;
        stall_f = 1'b0;
        step("hold_exc_release", 32'hBFC0_0380);

        // Decode stall: branch accepted exactly once, on the unstalled cycle
        stall_d = 1'b1;
        branch_valid = 1'b1; branch_taken = 1'b1; branch_target = 32'hBFC0_0600;
        #1;
        chk("sd_no_ds", ds_f, 32'd0);
        step("sd_wait1", 32'hBFC0_0384);
        step("sd_wait2", 32'hBFC0_0388);
        stall_d = 1'b0;
        #1;
        chk("sd_ds", ds_f, 32'd1);
        step("sd_accept", 32'hBFC0_0600);
        idle_inputs();
        step("sd_after", 32'hBFC0_0604);

        // Exception beats a same-cycle jump
        flush_exc = 1'b1; exc_pc = 32'hBFC0_0380;
        jump_valid = 1'b1; jump_target = 32'h8000_0000;
        #1;
        chk("exc_inst_req", inst_req, 32'd0);
        step("exc_over_jump", 32'hBFC0_0380);
        idle_inputs();

        // Asynchronous reset during HOLD discards the pending redirect
        stall_f = 1'b1;
        jump_valid = 1'b1; jump_target = 32'h1234_5678;
        step("pre_rst_hold", 32'hBFC0_0380);
        chk("pre_rst_pend", pend_o, 32'd1);
        idle_inputs();
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_pc",   pc_f,   32'hBFC0_0000);
        chk("async_rst_pend", pend_o, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step("post_rst", 32'hBFC0_0004);

        // Wrap-around and misaligned target
        jump_valid = 1'b1; jump_target = 32'hFFFF_FFF8;
        step("j_high", 32'hFFFF_FFF8);
        idle_inputs();
        step("wrap_pre", 32'hFFFF_FFFC);
        step("wrap", 32'h0000_0000);
        chk("wrap_adel", adel_f, 32'd0);
        jump_valid = 1'b1; jump_target = 32'h8000_0002;
        step("j_misaligned", 32'h8000_0002);
        chk("adel_set", adel_f, 32'd1);
        idle_inputs();
        step("misaligned_seq", 32'h8000_0006);
        chk("adel_hold", adel_f, 32'd1);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL sb_drain observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_redirect.md
PC_REDIRECT -- requirements
Module: pc_redirect

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'hBFC0_0000: fetch address loaded on reset.
REQ-002 The block SHALL have parameter EXC_PRIO, default 1: 1 = exception redirect overrides any branch/jump redirect in the same cycle.
REQ-003 clk  in  1  rising-edge clock; one clock, as already decided.
REQ-004 resetn  in  1  reset, asynchronous and active-low, as already decided.
REQ-005 stall_f  in  1  fetch stage stalled; the PC register holds.
REQ-006 stall_d  in  1  decode stage stalled; the branch/jump in decode is not yet accepted.
REQ-007 branch_valid  in  1  decode holds a conditional branch.
REQ-008 branch_taken  in  1  branch decision for the decode-stage branch; qualified by branch_valid.
REQ-009 branch_target  in  32  branch target address.
REQ-010 jump_valid  in  1  decode holds an unconditional jump (J/JAL/JR/JALR).
REQ-011 jump_target  in  32  jump target address.
REQ-012 flush_exc  in  1  exception/ERET redirect request, single-cycle pulse.
REQ-013 exc_pc  in  32  exception/ERET target address.
REQ-014 pc_f  out  32  current fetch address.
REQ-015 inst_req  out  1  fetch request valid.
REQ-016 ds_f  out  1  pc_f is the delay slot of an accepted branch/jump.
REQ-017 adel_f  out  1  pc_f misaligned (pc_f[1:0] != 2'b00).
REQ-018 pend_o  out  1  a redirect is held pending (debug/visibility).

Function
REQ-019 A branch/jump SHALL be accepted when (branch_valid|jump_valid) & ~stall_d; while stall_d=1 the same instruction SHALL NOT be accepted, and it SHALL be accepted exactly once.
REQ-020 An accepted branch redirects only if branch_taken=1 (target = branch_target); an accepted jump always redirects (target = jump_target); if both valid, jump_valid SHALL win.
REQ-021 Delay slot: at acceptance pc_f is the delay slot, which SHALL still be fetched; the redirect target SHALL become pc_f on the edge that advances past the delay slot.
REQ-022 ds_f SHALL be 1 in the cycle of acceptance (branch taken or not) and 0 otherwise.
REQ-023 State machine with two states: RUN and HOLD (redirect pending in a 32-bit pend_pc register).
REQ-024 RUN, ~stall_f: pc_f <= exc_pc if flush_exc, else redirect target if a redirect is accepted this cycle, else pc_f+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-025 RUN, stall_f, with a redirect accepted or flush_exc: pend_pc <= that target, go to HOLD, pc_f holds.
REQ-026 HOLD, stall_f: pc_f holds; flush_exc SHALL overwrite pend_pc with exc_pc; a new branch acceptance SHALL NOT overwrite pend_pc.
REQ-027 HOLD, ~stall_f: pc_f <= exc_pc if flush_exc this cycle, else pend_pc; return to RUN.
REQ-028 flush_exc SHALL take priority over every branch/jump in the same cycle (EXC_PRIO=1), and SHALL cancel any redirect from a branch accepted that cycle.
REQ-029 inst_req SHALL be 1 when resetn=1 and flush_exc=0, and 0 otherwise.
REQ-030 adel_f SHALL be pc_f[1:0]!=0, combinational; misaligned targets SHALL still be loaded unchanged.
REQ-031 pend_o SHALL be 1 exactly when the state is HOLD.
REQ-032 Redirect latency SHALL be one clock from acceptance (RUN, no stall) to pc_f = target.

Reset
REQ-033 While resetn=0: pc_f=RESET_PC, state=RUN, pend_pc=0, inst_req=0, ds_f=0, pend_o=0, adel_f=0.
REQ-034 Reset asserted mid-operation (including during HOLD) SHALL discard the pending redirect immediately, without waiting for a clock edge.
REQ-035 On the first edge after resetn rises, with no stall: pc_f = RESET_PC+4.

Verification
REQ-036 Reset release, 3 free cycles -> pc_f = BFC0_0000, BFC0_0004, BFC0_0008, BFC0_000C.
REQ-037 pc_f=BFC0_0010, branch_valid=1, branch_taken=1, branch_target=BFC0_0100 -> ds_f=1 that cycle; next pc_f = BFC0_0100.
REQ-038 Same branch as REQ-037 with stall_f=1 for 3 cycles -> pend_o=1 and pc_f holds; first unstalled edge gives pc_f = BFC0_0100, pend_o=0.
REQ-039 branch_valid=1 with stall_d=1 for 2 cycles, then stall_d=0 -> exactly one redirect, on the stall_d=0 cycle.
REQ-040 flush_exc=1, exc_pc=BFC0_0380, in the same cycle as jump_valid=1 to 8000_0000 -> pc_f = BFC0_0380 and inst_req=0 that cycle.
REQ-041 pc_f=FFFF_FFFC, no redirect -> pc_f = 0000_0000; jump_target=8000_0002 -> adel_f=1 after the redirect.
